// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the multi-channel debouncer.
package debounce_pkg;

  localparam int SYNC_STAGES = 2;
  localparam int PRESS_CNT_W = 8;

  // Stability counter width; never below one bit.
  function automatic int cnt_width(input int stable_cycles);
    int w;
    w = $clog2(stable_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser, stability counter, clean level
// and registered one-cycle rise/fall strobes.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 500000,
  parameter bit INIT_LEVEL    = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic noisy,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int              CNT_W    = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_out == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Level held long enough: accept it and strobe the direction.
      clean_d = sync_out;
      cnt_d   = '0;
      rise_d  = sync_out;
      fall_d  = ~sync_out;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
      cnt_q   <= '0;
      clean_q <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], noisy};
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean = clean_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/debounce_multi.sv
// N-channel debouncer with clean levels and rise/fall strobes.
// Optional saturating per-channel press counters: DEBOUNCE_MULTI_PRESS_COUNT_EN.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 500000,
  parameter bit INIT_LEVEL    = 1'b0
`ifdef DEBOUNCE_MULTI_PRESS_COUNT_EN
  ,
  parameter int CNT_SAT       = 255
`endif
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_CH-1:0]              noisy,
  output logic [N_CH-1:0]              clean,
  output logic [N_CH-1:0]              rise,
  output logic [N_CH-1:0]              fall
`ifdef DEBOUNCE_MULTI_PRESS_COUNT_EN
  ,
  input  logic                         cnt_clr,
  output logic [N_CH*PRESS_CNT_W-1:0]  press_cnt
`endif
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    debounce_chan #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .INIT_LEVEL    (INIT_LEVEL)
    ) u_chan (
      .clock (clock),
      .reset (reset),
      .noisy (noisy[i]),
      .clean (clean[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

`ifdef DEBOUNCE_MULTI_PRESS_COUNT_EN
  localparam logic [PRESS_CNT_W-1:0] PRESS_SAT = PRESS_CNT_W'(CNT_SAT);

  logic [PRESS_CNT_W-1:0] press_q [N_CH];
  logic [PRESS_CNT_W-1:0] press_d [N_CH];

  // Clear wins over a coincident strobe; counting stops at the ceiling.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      press_d[i] = press_q[i];
      if (cnt_clr) begin
        press_d[i] = '0;
      end else if (rise[i] && (press_q[i] != PRESS_SAT)) begin
        press_d[i] = press_q[i] + PRESS_CNT_W'(1);
      end else begin
        press_d[i] = press_q[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_CH; i++) begin
      if (reset) begin
        press_q[i] <= '0;
      end else begin
        press_q[i] <= press_d[i];
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_press
    assign press_cnt[i*PRESS_CNT_W +: PRESS_CNT_W] = press_q[i];
  end
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi using a sliding-window reference model.
module tb_debounce_multi;

  localparam int N    = 4;
  localparam int S    = 4;
  localparam bit INIT = 1'b0;
  localparam int SAT  = 255;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  noisy;
  logic [N-1:0]  clean, rise, fall;
  logic          cnt_clr;
`ifdef DEBOUNCE_MULTI_PRESS_COUNT_EN
  logic [N*8-1:0] press_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: last S+1 sampled inputs per channel, plus expected outputs.
  bit m_hist  [N][S+1];
  bit m_clean [N];
  bit m_rise  [N];
  bit m_fall  [N];
  int m_press [N];

  always #5 clock = ~clock;

  debounce_multi #(
    .N_CH          (N),
    .STABLE_CYCLES (S),
    .INIT_LEVEL    (INIT)
`ifdef DEBOUNCE_MULTI_PRESS_COUNT_EN
    ,
    .CNT_SAT       (SAT)
`endif
  ) dut (
    .clock (clock),
    .reset (reset),
    .noisy (noisy),
    .clean (clean),
    .rise  (rise),
    .fall  (fall)
`ifdef DEBOUNCE_MULTI_PRESS_COUNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .press_cnt (press_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A channel flips once the synchronised input (two edges late) has
  // disagreed with the clean level for S consecutive edges.
  task automatic model_edge();
    bit all_diff;
    for (int c = 0; c < N; c++) begin
      if (reset) begin
        m_clean[c] = INIT;
        m_rise[c]  = 1'b0;
        m_fall[c]  = 1'b0;
        m_press[c] = 0;
        for (int j = 0; j <= S; j++) m_hist[c][j] = INIT;
      end else begin
        if (cnt_clr) m_press[c] = 0;
        else if (m_rise[c] && m_press[c] < SAT) m_press[c]++;
        all_diff = 1'b1;
        for (int j = 1; j <= S; j++)
          if (m_hist[c][j] == m_clean[c]) all_diff = 1'b0;
        m_rise[c] = 1'b0;
        m_fall[c] = 1'b0;
        if (all_diff) begin
          m_clean[c] = ~m_clean[c];
          m_rise[c]  = m_clean[c];
          m_fall[c]  = ~m_clean[c];
        end
        for (int j = S; j >= 1; j--) m_hist[c][j] = m_hist[c][j-1];
        m_hist[c][0] = noisy[c];
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0] ec, er, ef;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    for (int c = 0; c < N; c++) begin
      ec[c] = m_clean[c];
      er[c] = m_rise[c];
      ef[c] = m_fall[c];
    end
    chk("clean", 32'(clean), 32'(ec));
    chk("rise",  32'(rise),  32'(er));
    chk("fall",  32'(fall),  32'(ef));
`ifdef DEBOUNCE_MULTI_PRESS_COUNT_EN
    for (int c = 0; c < N; c++)
      chk("press_cnt", 32'(press_cnt[c*8 +: 8]), 32'(m_press[c]));
`endif
  endtask

  // Ticks until clean[ch] reaches val; returns cycles taken (bounded).
  task automatic wait_clean(input int ch, input logic val, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (clean[ch] !== val && n < 20);
  endtask

  int  n;
  bit  seen;

  initial begin
    reset   = 1'b1;
    noisy   = '0;
    cnt_clr = 1'b0;
    repeat (3) tick();
    chk("reset_clean", 32'(clean), 32'(0));
    reset = 1'b0;
    repeat (8) tick();

    // Single step on ch0: exact latency and one rise.
    noisy[0] = 1'b1;
    wait_clean(0, 1'b1, n);
    chk("lat_rise0", 32'(n), 32'(S + 2));
    chk("rise0_strobe", 32'(rise[0]), 32'(1));
    tick();
    chk("rise0_once", 32'(rise[0]), 32'(0));

    // Bursts on ch1 shorter than S must be rejected.
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      noisy[1] = ~noisy[1];
      tick();
      seen |= clean[1] | rise[1];
      tick();
      seen |= clean[1] | rise[1];
    end
    chk("burst_reject1", 32'(seen), 32'(0));
    noisy[1] = 1'b1;
    wait_clean(1, 1'b1, n);
    chk("lat_settle1", 32'(n), 32'(S + 2));

    // Simultaneous transitions on ch2/ch3.
    noisy[3:2] = 2'b11;
    wait_clean(2, 1'b1, n);
    chk("lat_simul2", 32'(n), 32'(S + 2));
    chk("simul_rise", 32'(rise[3:2]), 32'(2'b11));
    repeat (3) tick();
    noisy[3] = 1'b0;
    wait_clean(3, 1'b0, n);
    chk("lat_fall3", 32'(n), 32'(S + 2));
    chk("fall3_strobe", 32'(fall[3]), 32'(1));

    // Reset mid-count on ch0; ch1/ch2 held high must re-qualify from zero.
    noisy[0] = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_clean", 32'(clean), 32'(0));
    wait_clean(1, 1'b1, n);
    chk("lat_requal1", 32'(n), 32'(S + 2));
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen |= fall[0] | clean[0];
    end
    chk("rst_no_fall0", 32'(seen), 32'(0));

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 5) == 0) noisy[c] = ~noisy[c];
      reset = ($urandom_range(0, 199) == 0);
`ifdef DEBOUNCE_MULTI_PRESS_COUNT_EN
      cnt_clr = ($urandom_range(0, 49) == 0);
`endif
      tick();
    end
    reset   = 1'b0;
    cnt_clr = 1'b0;
    noisy   = '0;
    repeat (10) tick();

`ifdef DEBOUNCE_MULTI_PRESS_COUNT_EN
    // Saturation after many presses, then clear against a coincident strobe.
    for (int i = 0; i < 300; i++) begin
      noisy[0] = 1'b1;
      repeat (S + 3) tick();
      noisy[0] = 1'b0;
      repeat (S + 3) tick();
    end
    chk("press_sat", 32'(press_cnt[7:0]), 32'(SAT));
    noisy[0] = 1'b1;
    wait_clean(0, 1'b1, n);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("press_clr", 32'(press_cnt[7:0]), 32'(0));
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
